i2c_arbiter: RTL and testbench

//  Shares one i2c_master between NREQ requesters (e.g. read_eeprom and a future write_eeprom).
//  - Round-robin grant.
//  - Latches the winner's transaction descriptor and drives the master's start handshake.
//  - Routes per-byte data strobes to the granted requester only.
//  - Sits between the requester FSMs and i2c_master; runs on the same clock as i2c_master.

---
 rtl/i2c_arbiter.sv | 173 +++++++++++++++++
 tb/tb_i2c_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one i2c_master among NREQ requesters:
// latches the winner's descriptor, runs the start handshake and routes data strobes to the owner.
module i2c_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*8-1:0]   req_nbytes,
  input  logic [NREQ*7-1:0]   req_addr,
  input  logic [NREQ-1:0]     req_rw,
  input  logic [NREQ*8-1:0]   req_write_data,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     done,
  output logic                err,
  output logic [7:0]          req_read_data,
  output logic [NREQ-1:0]     req_tx_data_req,
  output logic [NREQ-1:0]     req_rx_data_ready,
  output logic                m_start,
  output logic [7:0]          m_nbytes,
  output logic [6:0]          m_addr,
  output logic                m_rw,
  output logic [7:0]          m_write_data,
  input  logic [7:0]          m_read_data,
  input  logic                m_tx_data_req,
  input  logic                m_rx_data_ready,
  input  logic                m_ready,
  input  logic                m_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [NREQ-1:0] rr_reg, rr_next;
  logic [TW-1:0]   cnt_reg, cnt_next;
  logic            err_reg, err_next;
  logic [7:0]      nbytes_reg, nbytes_next;
  logic [6:0]      addr_reg, addr_next;
  logic            rw_reg, rw_next;

  logic [NREQ-1:0] hi_req;
  logic [NREQ-1:0] pick_vec;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] rr_rot;
  logic [7:0]      sel_nbytes;
  logic [6:0]      sel_addr;
  logic            sel_rw;
  logic [7:0]      sel_wdata;
  logic            active;

  // rr_reg is one-hot; requests at or above it take priority, else wrap to the lowest request.
  assign hi_req   = req & ~(rr_reg - NREQ'(1));
  assign pick_vec = (|hi_req) ? hi_req : req;
  assign win_oh   = pick_vec & (~pick_vec + NREQ'(1));

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    assign rr_rot[gi] = grant_reg[(gi + NREQ - 1) % NREQ];
  end

  // Bit-sliced AND-OR muxes keyed by a one-hot select.
  for (genvar gb = 0; gb < 8; gb++) begin : g_byte
    logic [NREQ-1:0] nb_col;
    logic [NREQ-1:0] wd_col;
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign nb_col[gi] = req_nbytes[8*gi + gb];
      assign wd_col[gi] = req_write_data[8*gi + gb];
    end
    assign sel_nbytes[gb] = |(nb_col & win_oh);
    assign sel_wdata[gb]  = |(wd_col & grant_reg);
  end

  for (genvar gb = 0; gb < 7; gb++) begin : g_addr
    logic [NREQ-1:0] ad_col;
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign ad_col[gi] = req_addr[7*gi + gb];
    end
    assign sel_addr[gb] = |(ad_col & win_oh);
  end

  assign sel_rw = |(req_rw & win_oh);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      grant_reg  <= '0;
      rr_reg     <= NREQ'(1);
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
      nbytes_reg <= '0;
      addr_reg   <= '0;
      rw_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_reg     <= rr_next;
      cnt_reg    <= cnt_next;
      err_reg    <= err_next;
      nbytes_reg <= nbytes_next;
      addr_reg   <= addr_next;
      rw_reg     <= rw_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_next     = rr_reg;
    cnt_next    = cnt_reg;
    err_next    = err_reg;
    nbytes_next = nbytes_reg;
    addr_next   = addr_reg;
    rw_next     = rw_reg;
    case (state_reg)
      S_IDLE: begin
        if (|req && m_ready && !m_busy) begin
          grant_next  = win_oh;
          nbytes_next = sel_nbytes;
          addr_next   = sel_addr;
          rw_next     = sel_rw;
          cnt_next    = '0;
          err_next    = 1'b0;
          state_next  = S_START;
        end
      end
      S_START: begin
        if (m_busy) begin
          state_next = S_RUN;
        end else if (cnt_reg == TW'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg + TW'(1);
        end
      end
      S_RUN: begin
        if (!m_busy) state_next = S_DONE;
      end
      S_DONE: begin
        rr_next     = rr_rot;
        grant_next  = '0;
        nbytes_next = '0;
        addr_next   = '0;
        rw_next     = 1'b0;
        cnt_next    = '0;
        err_next    = 1'b0;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign active            = (state_reg == S_START) || (state_reg == S_RUN);
  assign grant             = grant_reg;
  assign done              = (state_reg == S_DONE) ? grant_reg : '0;
  assign err               = (state_reg == S_DONE) && err_reg;
  assign m_start           = (state_reg == S_START);
  assign m_nbytes          = nbytes_reg;
  assign m_addr            = addr_reg;
  assign m_rw              = rw_reg;
  assign m_write_data      = active ? sel_wdata : '0;
  assign req_read_data     = m_read_data;
  assign req_tx_data_req   = active ? (grant_reg & {NREQ{m_tx_data_req}}) : '0;
  assign req_rx_data_ready = active ? (grant_reg & {NREQ{m_rx_data_ready}}) : '0;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Randomized self-checking bench for i2c_arbiter against a behavioural round-robin model.
module tb_i2c_arbiter;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 1023;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*8-1:0]   req_nbytes;
  logic [NREQ*7-1:0]   req_addr;
  logic [NREQ-1:0]     req_rw;
  logic [NREQ*8-1:0]   req_write_data;
  logic [NREQ-1:0]     grant, done, req_tx_data_req, req_rx_data_ready;
  logic                err, m_start, m_rw;
  logic [7:0]          req_read_data, m_nbytes, m_write_data, m_read_data;
  logic [6:0]          m_addr;
  logic                m_tx_data_req, m_rx_data_ready, m_ready, m_busy;

  logic [7:0] nb [NREQ];
  logic [6:0] ad [NREQ];
  logic [7:0] wd [NREQ];

  int checks = 0;
  int errors = 0;
  int rr_m   = 0;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign req_nbytes[8*gi +: 8]     = nb[gi];
    assign req_addr[7*gi +: 7]       = ad[gi];
    assign req_write_data[8*gi +: 8] = wd[gi];
  end

  i2c_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(10)) dut (
    .clk(clk), .reset(reset), .req(req), .req_nbytes(req_nbytes), .req_addr(req_addr),
    .req_rw(req_rw), .req_write_data(req_write_data), .grant(grant), .done(done), .err(err),
    .req_read_data(req_read_data), .req_tx_data_req(req_tx_data_req),
    .req_rx_data_ready(req_rx_data_ready), .m_start(m_start), .m_nbytes(m_nbytes),
    .m_addr(m_addr), .m_rw(m_rw), .m_write_data(m_write_data), .m_read_data(m_read_data),
    .m_tx_data_req(m_tx_data_req), .m_rx_data_ready(m_rx_data_ready), .m_ready(m_ready),
    .m_busy(m_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First requester at or after the pointer, scanning with wrap-around.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic randomize_fields();
    for (int i = 0; i < NREQ; i++) begin
      nb[i]     = 8'($urandom);
      ad[i]     = 7'($urandom);
      wd[i]     = 8'($urandom);
      req_rw[i] = 1'($urandom);
    end
  endtask

  // One full transaction: grant, start handshake, busy phase with strobes, done pulse.
  task automatic run_txn(input int exp_owner, input int start_lat, input int busy_len, input bit drop);
    logic [NREQ-1:0] eg;
    int rx_issued, rx_seen;
    bit rx, tx;
    eg = '0;
    eg[exp_owner] = 1'b1;
    rx_issued = 0;
    rx_seen = 0;
    m_ready = 1'b1;
    m_busy = 1'b0;
    step();
    checks++; if (grant !== eg) begin errors++; $display("FAIL grant got %b exp %b", grant, eg); end
    checks++; if (m_start !== 1'b1) begin errors++; $display("FAIL start_rise got %b exp 1", m_start); end
    checks++; if (m_addr !== ad[exp_owner]) begin errors++; $display("FAIL m_addr got %h exp %h", m_addr, ad[exp_owner]); end
    checks++; if (m_nbytes !== nb[exp_owner]) begin errors++; $display("FAIL m_nbytes got %h exp %h", m_nbytes, nb[exp_owner]); end
    checks++; if (m_rw !== req_rw[exp_owner]) begin errors++; $display("FAIL m_rw got %b exp %b", m_rw, req_rw[exp_owner]); end
    checks++; if (m_write_data !== wd[exp_owner]) begin errors++; $display("FAIL m_write_data got %h exp %h", m_write_data, wd[exp_owner]); end
    for (int i = 0; i < start_lat; i++) begin
      step();
      checks++; if (m_start !== 1'b1) begin errors++; $display("FAIL start_hold got %b exp 1", m_start); end
    end
    m_busy = 1'b1;
    m_ready = 1'b0;
    step();
    checks++; if (m_start !== 1'b0) begin errors++; $display("FAIL start_drop got %b exp 0", m_start); end
    for (int k = 0; k < busy_len; k++) begin
      rx = ($urandom_range(0, 3) == 0);
      tx = !rx && ($urandom_range(0, 2) == 0);
      m_rx_data_ready = rx;
      m_tx_data_req = tx;
      m_read_data = 8'($urandom);
      if (drop && k == busy_len / 2) req[exp_owner] = 1'b0;
      if (rx) rx_issued++;
      #1;
      if (req_rx_data_ready[exp_owner]) rx_seen++;
      checks++; if (req_rx_data_ready !== (rx ? eg : '0)) begin errors++; $display("FAIL rx_route got %b exp %b", req_rx_data_ready, rx ? eg : '0); end
      checks++; if (req_tx_data_req !== (tx ? eg : '0)) begin errors++; $display("FAIL tx_route got %b exp %b", req_tx_data_req, tx ? eg : '0); end
      checks++; if (req_read_data !== m_read_data) begin errors++; $display("FAIL read_data got %h exp %h", req_read_data, m_read_data); end
      checks++; if (m_write_data !== wd[exp_owner]) begin errors++; $display("FAIL wdata_run got %h exp %h", m_write_data, wd[exp_owner]); end
      step();
    end
    m_rx_data_ready = 1'b0;
    m_tx_data_req = 1'b0;
    checks++; if (rx_seen !== rx_issued) begin errors++; $display("FAIL rx_count got %0d exp %0d", rx_seen, rx_issued); end
    checks++; if (grant !== eg) begin errors++; $display("FAIL grant_run got %b exp %b", grant, eg); end
    m_busy = 1'b0;
    m_ready = 1'b1;
    step();
    checks++; if (done !== eg) begin errors++; $display("FAIL done got %b exp %b", done, eg); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err got %b exp 0", err); end
    checks++; if (m_addr !== ad[exp_owner]) begin errors++; $display("FAIL addr_held got %h exp %h", m_addr, ad[exp_owner]); end
    checks++; if (m_write_data !== 8'h00) begin errors++; $display("FAIL wdata_done got %h exp 00", m_write_data); end
    step();
    checks++; if (done !== '0) begin errors++; $display("FAIL done_pulse got %b exp 0", done); end
    checks++; if (grant !== '0) begin errors++; $display("FAIL grant_idle got %b exp 0", grant); end
    checks++; if (m_nbytes !== 8'h00 || m_addr !== 7'h00) begin errors++; $display("FAIL m_clear got %h/%h exp 00/00", m_nbytes, m_addr); end
    rr_m = (exp_owner + 1) % NREQ;
    $display("txn owner=%0d addr=%h nbytes=%0d rw=%b start_lat=%0d busy=%0d rx=%0d", exp_owner, ad[exp_owner], nb[exp_owner], req_rw[exp_owner], start_lat, busy_len, rx_issued);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = '1;
    m_ready = 1'b1;
    m_busy = 1'b0;
    m_read_data = '0;
    m_tx_data_req = 1'b1;
    m_rx_data_ready = 1'b1;
    randomize_fields();
    repeat (3) step();
    checks++; if (grant !== '0 || done !== '0 || err !== 1'b0) begin errors++; $display("FAIL reset_ctl got %b/%b/%b exp 0", grant, done, err); end
    checks++; if (m_start !== 1'b0 || m_rw !== 1'b0) begin errors++; $display("FAIL reset_start got %b/%b exp 0", m_start, m_rw); end
    checks++; if (m_nbytes !== '0 || m_addr !== '0 || m_write_data !== '0) begin errors++; $display("FAIL reset_m got %h/%h/%h exp 0", m_nbytes, m_addr, m_write_data); end
    checks++; if (req_tx_data_req !== '0 || req_rx_data_ready !== '0) begin errors++; $display("FAIL reset_route got %b/%b exp 0", req_tx_data_req, req_rx_data_ready); end
    m_tx_data_req = 1'b0;
    m_rx_data_ready = 1'b0;
    req = '0;
    reset = 1'b1;
    rr_m = 0;
    step();
  endtask

  task automatic test_round_robin();
    randomize_fields();
    nb[1] = 8'h00;
    req = 2'b11;
    run_txn(0, 1, 4, 1'b0);
    run_txn(1, 0, 3, 1'b0);
    run_txn(0, 2, 5, 1'b0);
    req = '0;
  endtask

  task automatic test_single_read();
    randomize_fields();
    ad[0] = 7'h50;
    nb[0] = 8'd2;
    req_rw[0] = 1'b1;
    req = 2'b01;
    run_txn(model_pick(req, rr_m), 1, 40, 1'b0);
    req = '0;
  endtask

  task automatic test_not_ready();
    randomize_fields();
    req = 2'b10;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (grant !== '0 || m_start !== 1'b0) begin errors++; $display("FAIL not_ready got grant %b start %b exp 0", grant, m_start); end
    end
    run_txn(model_pick(req, rr_m), 0, 6, 1'b0);
    req = '0;
  endtask

  task automatic test_timeout();
    int cnt;
    int owner;
    randomize_fields();
    req = 2'b01;
    m_ready = 1'b1;
    m_busy = 1'b0;
    owner = model_pick(req, rr_m);
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL to_grant got %b exp 01", grant); end
    cnt = 0;
    while (m_start && cnt < 2000) begin
      cnt++;
      step();
    end
    checks++; if (cnt !== TIMEOUT) begin errors++; $display("FAIL to_cycles got %0d exp %0d", cnt, TIMEOUT); end
    checks++; if (done !== 2'b01 || err !== 1'b1) begin errors++; $display("FAIL to_done got done %b err %b exp 01/1", done, err); end
    req = '0;
    step();
    checks++; if (grant !== '0 || err !== 1'b0 || done !== '0) begin errors++; $display("FAIL to_after got %b/%b/%b exp 0", grant, err, done); end
    rr_m = (owner + 1) % NREQ;
    $display("txn owner=%0d timeout start_cycles=%0d", owner, cnt);
  endtask

  task automatic test_owner_drop();
    int first;
    randomize_fields();
    req = 2'b11;
    first = model_pick(req, rr_m);
    run_txn(first, 1, 10, 1'b1);
    run_txn(model_pick(req, rr_m), 0, 4, 1'b0);
    req = '0;
  endtask

  task automatic test_reset_mid_run();
    randomize_fields();
    req = 2'b01;
    m_ready = 1'b1;
    m_busy = 1'b0;
    step();
    m_busy = 1'b1;
    m_ready = 1'b0;
    step();
    repeat (3) step();
    #2 reset = 1'b0;
    #1;
    checks++; if (grant !== '0 || m_start !== 1'b0 || done !== '0) begin errors++; $display("FAIL rst_run got %b/%b/%b exp 0", grant, m_start, done); end
    checks++; if (m_addr !== '0 || m_nbytes !== '0 || m_rw !== 1'b0) begin errors++; $display("FAIL rst_m got %h/%h/%b exp 0", m_addr, m_nbytes, m_rw); end
    m_busy = 1'b0;
    m_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++; if (done !== '0 || grant !== '0) begin errors++; $display("FAIL rst_hold got %b/%b exp 0", done, grant); end
    end
    reset = 1'b1;
    rr_m = 0;
    req = 2'b11;
    run_txn(model_pick(req, rr_m), 1, 5, 1'b0);
    req = '0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      randomize_fields();
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      run_txn(model_pick(req, rr_m), $urandom_range(0, 5), $urandom_range(1, 8), 1'($urandom_range(0, 1)));
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_not_ready();
    test_timeout();
    test_owner_drop();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
